// File: rtl/idecode_if.sv
// Signal bundle of the MIPS decode stage: IF/ID inputs, WB write-back port,
// ID/EX pipeline outputs and the load-use stall flag to fetch.
interface idecode_if #(
  parameter int PARAM_PC_bits = 10
);
  logic [31:0]              ip_instruction;
  logic [PARAM_PC_bits-1:0] ip_PC_plus_4;
  logic                     ip_flush;
  logic                     ip_reg_write;
  logic [4:0]               ip_write_reg;
  logic [31:0]              ip_write_data;

  logic                     op_stall;
  logic [31:0]              op_read_data_1;
  logic [31:0]              op_read_data_2;
  logic [31:0]              op_sign_extend;
  logic [4:0]               op_rt;
  logic [4:0]               op_rd;
  logic [PARAM_PC_bits-1:0] op_PC_plus_4;
  logic                     op_reg_dst;
  logic                     op_alu_src;
  logic                     op_mem_to_reg;
  logic                     op_reg_write;
  logic                     op_mem_read;
  logic                     op_mem_write;
  logic                     op_branch;
  logic [1:0]               op_alu_op;

  modport master (
    output ip_instruction, ip_PC_plus_4, ip_flush,
    output ip_reg_write, ip_write_reg, ip_write_data,
    input  op_stall, op_read_data_1, op_read_data_2, op_sign_extend,
    input  op_rt, op_rd, op_PC_plus_4,
    input  op_reg_dst, op_alu_src, op_mem_to_reg, op_reg_write,
    input  op_mem_read, op_mem_write, op_branch, op_alu_op
  );

  modport slave (
    input  ip_instruction, ip_PC_plus_4, ip_flush,
    input  ip_reg_write, ip_write_reg, ip_write_data,
    output op_stall, op_read_data_1, op_read_data_2, op_sign_extend,
    output op_rt, op_rd, op_PC_plus_4,
    output op_reg_dst, op_alu_src, op_mem_to_reg, op_reg_write,
    output op_mem_read, op_mem_write, op_branch, op_alu_op
  );
endinterface

// File: rtl/idecode_stage.sv
// MIPS instruction-decode stage: register file with WB bypass, main control,
// sign extension, load-use hazard detection and the ID/EX pipeline register.
module idecode_stage #(
  parameter int PARAM_REG_count = 32,
  parameter int PARAM_PC_bits   = 10
) (
  input  logic     clock,
  input  logic     reset,
  idecode_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t                    ctrl;
    logic [31:0]              read_data_1;
    logic [31:0]              read_data_2;
    logic [31:0]              sign_extend;
    logic [4:0]               rt;
    logic [4:0]               rd;
    logic [PARAM_PC_bits-1:0] pc_plus_4;
  } idex_t;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  assign opcode = bus.ip_instruction[31:26];
  assign rs     = bus.ip_instruction[25:21];
  assign rt     = bus.ip_instruction[20:16];
  assign rd     = bus.ip_instruction[15:11];
  assign imm    = bus.ip_instruction[15:0];

  // Main control; unknown opcodes decode to an all-zero bubble.
  ctrl_t ctrl_dec;
  logic  uses_rt;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ctrl_dec = '0;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_dec.reg_dst   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = 2'b10;
        uses_rt            = 1'b1;
      end
      OP_LW: begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_BEQ: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = 2'b01;
        uses_rt         = 1'b1;
      end
      OP_ADDI: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file; $0 is never written and always reads as zero.
  logic [31:0] rf_q [PARAM_REG_count];
  logic        wb_en;

  assign wb_en = bus.ip_reg_write && (bus.ip_write_reg != 5'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the architectural register file must read as zero after reset,
      // so this array is cleared here unlike a plain data RAM; state updates
      // use non-blocking assignments so all flops sample the same old values.
      for (int i = 0; i < PARAM_REG_count; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      rf_q[bus.ip_write_reg] <= bus.ip_write_data;
    end
  end

  // Same-cycle WB bypass: a write in flight wins over the stored value.
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;

  always_comb begin
    rd_data_1 = '0;
    rd_data_2 = '0;
    if (rs != 5'd0) begin
      rd_data_1 = (wb_en && (bus.ip_write_reg == rs)) ? bus.ip_write_data : rf_q[rs];
    end
    if (rt != 5'd0) begin
      rd_data_2 = (wb_en && (bus.ip_write_reg == rt)) ? bus.ip_write_data : rf_q[rt];
    end
  end

  idex_t idex_q;
  idex_t idex_d;
  logic  hazard;

  // rt only counts as a source for opcodes that actually read it.
  assign hazard = idex_q.ctrl.mem_read && (idex_q.rt != 5'd0) &&
                  ((idex_q.rt == rs) || ((idex_q.rt == rt) && uses_rt));

  assign bus.op_stall = hazard && !bus.ip_flush;

  // Flush clears the whole entry; a hazard inserts a bubble but keeps data.
  always_comb begin
    idex_d = '0;
    if (!bus.ip_flush) begin
      idex_d.ctrl        = hazard ? '0 : ctrl_dec;
      idex_d.read_data_1 = rd_data_1;
      idex_d.read_data_2 = rd_data_2;
      idex_d.sign_extend = {{16{imm[15]}}, imm};
      idex_d.rt          = rt;
      idex_d.rd          = rd;
      idex_d.pc_plus_4   = bus.ip_PC_plus_4;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.op_read_data_1 = idex_q.read_data_1;
  assign bus.op_read_data_2 = idex_q.read_data_2;
  assign bus.op_sign_extend = idex_q.sign_extend;
  assign bus.op_rt          = idex_q.rt;
  assign bus.op_rd          = idex_q.rd;
  assign bus.op_PC_plus_4   = idex_q.pc_plus_4;
  assign bus.op_reg_dst     = idex_q.ctrl.reg_dst;
  assign bus.op_alu_src     = idex_q.ctrl.alu_src;
  assign bus.op_mem_to_reg  = idex_q.ctrl.mem_to_reg;
  assign bus.op_reg_write   = idex_q.ctrl.reg_write;
  assign bus.op_mem_read    = idex_q.ctrl.mem_read;
  assign bus.op_mem_write   = idex_q.ctrl.mem_write;
  assign bus.op_branch      = idex_q.ctrl.branch;
  assign bus.op_alu_op      = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_idecode_stage.sv
// Bench for idecode_stage: directed scenarios plus a randomized run checked
// against a register-array model of the decode stage.
module tb_idecode_stage;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  idecode_if #(.PARAM_PC_bits(10)) bus ();

  idecode_stage #(.PARAM_REG_count(32), .PARAM_PC_bits(10)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
  logic [8:0]   dut_ctrl;
  logic [125:0] all_outs;
  assign dut_ctrl = {bus.op_reg_dst, bus.op_alu_src, bus.op_mem_to_reg, bus.op_reg_write,
                     bus.op_mem_read, bus.op_mem_write, bus.op_branch, bus.op_alu_op};
  assign all_outs = {bus.op_stall, bus.op_read_data_1, bus.op_read_data_2, bus.op_sign_extend,
                     bus.op_rt, bus.op_rd, bus.op_PC_plus_4, dut_ctrl};

  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b1_0_0_1_0_0_0_10;
      6'h23:   return 9'b0_1_1_1_1_0_0_00;
      6'h2B:   return 9'b0_1_0_0_0_1_0_00;
      6'h04:   return 9'b0_0_0_0_0_0_1_01;
      6'h08:   return 9'b0_1_0_1_0_0_0_00;
      default: return 9'b0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [9:0] pc, input logic flush,
                       input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
    bus.ip_instruction = instr;
    bus.ip_PC_plus_4   = pc;
    bus.ip_flush       = flush;
    bus.ip_reg_write   = we;
    bus.ip_write_reg   = wreg;
    bus.ip_write_data  = wdata;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h8C090000, 10'h3FF, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF);
    #2;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    tick();
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_held_outputs: got %h expected 0", all_outs);
    end
    drive(32'h0, 10'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_rtype_writeback();
    drive(32'h0, 10'h004, 1'b0, 1'b1, 5'd9, 32'h55555555);
    tick();
    drive(32'h01220820, 10'h008, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (bus.op_read_data_1 !== 32'h55555555) begin
      errors++;
      $display("FAIL rtype_rd1: got %h expected %h", bus.op_read_data_1, 32'h55555555);
    end
    checks++;
    if (bus.op_rd !== 5'd1 || bus.op_rt !== 5'd2 || bus.op_PC_plus_4 !== 10'h008) begin
      errors++;
      $display("FAIL rtype_fields: got rd=%0d rt=%0d pc=%h expected rd=1 rt=2 pc=008",
               bus.op_rd, bus.op_rt, bus.op_PC_plus_4);
    end
    checks++;
    if (dut_ctrl !== 9'b1_0_0_1_0_0_0_10) begin
      errors++;
      $display("FAIL rtype_ctrl: got %b expected %b", dut_ctrl, 9'b1_0_0_1_0_0_0_10);
    end
  endtask

  task automatic test_bypass();
    drive(32'h00221020, 10'h00C, 1'b0, 1'b1, 5'd2, 32'h00000002);
    tick();
    checks++;
    if (bus.op_read_data_2 !== 32'h00000002 || bus.op_read_data_1 !== 32'h0) begin
      errors++;
      $display("FAIL bypass_same_cycle: got rd1=%h rd2=%h expected rd1=0 rd2=2",
               bus.op_read_data_1, bus.op_read_data_2);
    end
    drive(32'h00221020, 10'h010, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (bus.op_read_data_2 !== 32'h00000002) begin
      errors++;
      $display("FAIL bypass_stored: got %h expected 2", bus.op_read_data_2);
    end
  endtask

  task automatic test_load_use();
    drive(32'h8C090000, 10'h014, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.op_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_no_stall_on_lw: got %b expected 0", bus.op_stall);
    end
    tick();
    checks++;
    if (dut_ctrl !== 9'b0_1_1_1_1_0_0_00 || bus.op_rt !== 5'd9) begin
      errors++;
      $display("FAIL lu_lw_decode: got ctrl=%b rt=%0d expected ctrl=011110000 rt=9",
               dut_ctrl, bus.op_rt);
    end
    drive(32'h01220820, 10'h018, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.op_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b expected 1", bus.op_stall);
    end
    tick();
    checks++;
    if (dut_ctrl !== 9'b0 || bus.op_read_data_1 !== 32'h55555555 || bus.op_read_data_2 !== 32'h2) begin
      errors++;
      $display("FAIL lu_bubble: got ctrl=%b rd1=%h rd2=%h expected ctrl=0 rd1=55555555 rd2=2",
               dut_ctrl, bus.op_read_data_1, bus.op_read_data_2);
    end
    checks++;
    if (bus.op_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall_one_cycle: got %b expected 0", bus.op_stall);
    end
    tick();
    checks++;
    if (dut_ctrl !== 9'b1_0_0_1_0_0_0_10 || bus.op_rd !== 5'd1) begin
      errors++;
      $display("FAIL lu_add_after_stall: got ctrl=%b rd=%0d expected ctrl=100100010 rd=1",
               dut_ctrl, bus.op_rd);
    end
  endtask

  task automatic test_back_to_back_lw();
    drive(32'h8C090000, 10'h01C, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h8D2A0000, 10'h020, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.op_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall: got %b expected 1", bus.op_stall);
    end
    tick();
    tick();
    checks++;
    if (bus.op_mem_read !== 1'b1 || bus.op_rt !== 5'd10) begin
      errors++;
      $display("FAIL b2b_second_lw: got mem_read=%b rt=%0d expected mem_read=1 rt=10",
               bus.op_mem_read, bus.op_rt);
    end
    drive(32'h01420820, 10'h024, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.op_stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_consumer_stall: got %b expected 1", bus.op_stall);
    end
    tick();
    drive(32'h0, 10'h028, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_flush_hazard();
    drive(32'h8C090000, 10'h02C, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h01220820, 10'h030, 1'b1, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.op_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b expected 0", bus.op_stall);
    end
    tick();
    checks++;
    if (dut_ctrl !== 9'b0) begin
      errors++;
      $display("FAIL flush_ctrl: got %b expected 0", dut_ctrl);
    end
    drive(32'h01220820, 10'h034, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.op_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_stall_after: got %b expected 0", bus.op_stall);
    end
    tick();
  endtask

  task automatic test_beq();
    drive(32'h1021FFFC, 10'h038, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (dut_ctrl !== 9'b0_0_0_0_0_0_1_01 || bus.op_sign_extend !== 32'hFFFFFFFC) begin
      errors++;
      $display("FAIL beq_neg: got ctrl=%b se=%h expected ctrl=000000101 se=fffffffc",
               dut_ctrl, bus.op_sign_extend);
    end
    drive(32'h102100FC, 10'h03C, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (bus.op_branch !== 1'b1 || bus.op_sign_extend !== 32'h000000FC) begin
      errors++;
      $display("FAIL beq_pos: got branch=%b se=%h expected branch=1 se=000000fc",
               bus.op_branch, bus.op_sign_extend);
    end
  endtask

  task automatic test_zero_reg();
    drive(32'h00000820, 10'h040, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    checks++;
    if (bus.op_read_data_1 !== 32'h0 || bus.op_read_data_2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_bypass: got rd1=%h rd2=%h expected 0 0",
               bus.op_read_data_1, bus.op_read_data_2);
    end
    drive(32'h00000820, 10'h044, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checks++;
    if (bus.op_read_data_1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_stored: got %h expected 0", bus.op_read_data_1);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h8C090000, 10'h048, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    drive(32'h01220820, 10'h04C, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus.op_stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall_setup: got %b expected 1", bus.op_stall);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL mid_stall_reset: got %h expected 0", all_outs);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.op_read_data_1 !== 32'h0 || dut_ctrl !== 9'b1_0_0_1_0_0_0_10) begin
      errors++;
      $display("FAIL mid_stall_rf_cleared: got rd1=%h ctrl=%b expected rd1=0 ctrl=100100010",
               bus.op_read_data_1, dut_ctrl);
    end
  endtask

  task automatic test_random();
    logic [31:0] rf [32];
    logic        prev_mr;
    logic [4:0]  prev_rt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, wreg;
    logic [15:0] low;
    logic [31:0] instr, wdata, e_rd1, e_rd2, e_se;
    logic [9:0]  pc;
    logic        flush, we, hz, e_stall;
    logic [8:0]  e_ctrl;

    reset = 1'b1;
    drive(32'h0, 10'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    prev_mr = 1'b0;
    prev_rt = 5'd0;

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       op = 6'h00;
        1:       op = 6'h23;
        2:       op = 6'h2B;
        3:       op = 6'h04;
        4:       op = 6'h08;
        default: op = 6'($urandom_range(0, 63));
      endcase
      rs    = 5'($urandom_range(0, 4));
      rt    = 5'($urandom_range(0, 4));
      low   = 16'($urandom);
      instr = {op, rs, rt, low};
      pc    = 10'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      we    = 1'($urandom_range(0, 1));
      wreg  = 5'($urandom_range(0, 5));
      wdata = $urandom;

      e_rd1 = (rs == 0) ? 32'h0 : ((we && wreg != 0 && wreg == rs) ? wdata : rf[rs]);
      e_rd2 = (rt == 0) ? 32'h0 : ((we && wreg != 0 && wreg == rt) ? wdata : rf[rt]);
      e_se  = {{16{low[15]}}, low};
      hz = prev_mr && (prev_rt != 0) &&
           ((prev_rt == rs) || ((prev_rt == rt) && (op == 6'h00 || op == 6'h2B || op == 6'h04)));
      e_stall = hz && !flush;
      e_ctrl  = (flush || hz) ? 9'b0 : ctrl_of(op);

      drive(instr, pc, flush, we, wreg, wdata);
      #1;
      checks++;
      if (bus.op_stall !== e_stall) begin
        errors++;
        $display("FAIL rand_stall[%0d]: got %b expected %b (instr %h)", n, bus.op_stall, e_stall, instr);
      end
      tick();
      checks++;
      if (dut_ctrl !== e_ctrl) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got %b expected %b (instr %h)", n, dut_ctrl, e_ctrl, instr);
      end
      if (!flush) begin
        checks++;
        if (bus.op_read_data_1 !== e_rd1 || bus.op_read_data_2 !== e_rd2) begin
          errors++;
          $display("FAIL rand_regs[%0d]: got %h %h expected %h %h", n,
                   bus.op_read_data_1, bus.op_read_data_2, e_rd1, e_rd2);
        end
        checks++;
        if (bus.op_sign_extend !== e_se || bus.op_rt !== rt || bus.op_rd !== low[15:11] ||
            bus.op_PC_plus_4 !== pc) begin
          errors++;
          $display("FAIL rand_fields[%0d]: got se=%h rt=%0d rd=%0d pc=%h expected se=%h rt=%0d rd=%0d pc=%h",
                   n, bus.op_sign_extend, bus.op_rt, bus.op_rd, bus.op_PC_plus_4,
                   e_se, rt, low[15:11], pc);
        end
      end

      if (we && wreg != 0) rf[wreg] = wdata;
      prev_mr = e_ctrl[4];
      prev_rt = flush ? 5'd0 : rt;
    end
  endtask

  initial begin
    test_reset();
    test_rtype_writeback();
    test_bypass();
    test_load_use();
    test_back_to_back_lw();
    test_flush_hazard();
    test_beq();
    test_zero_reg();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
